operand_bypass: RTL and testbench

Decode-stage consumer of the forward_data_out buses, sitting between decode and execute. Resolves rs1/rs2 operands from the EX, MEM and WB forward buses, the long-latency completion port, or the register file. Tracks in-flight long-latency writes (loads, mul/div) in a 32-entry busy scoreboard and stalls decode on RAW/WAW hazards. Delivers operands to execute through a registered valid/ready pipeline stage.

---
 rtl/operand_bypass.sv | 133 +++++++++++++
 tb/tb_operand_bypass.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - decode-stage operand bypass with long-latency busy scoreboard
//
// Purpose: resolves rs1/rs2 from the EX/MEM/WB forward buses, the long-latency
// completion port or the register file; stalls decode on RAW/WAW hazards
// against in-flight long-latency writes; hands operands to execute through a
// registered valid/ready stage.
//
// Optional feature macro: STALL_CNT_EN (hazard-stall cycle counter on stall_cnt).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   fwd_ex/fwd_mem/fwd_wb [69:0]    forward buses {valid[69], dst[68:64], data[63:0]}
//   done_valid/done_dst/done_data   long-latency completion port
//   in_valid/in_ready               decode handshake
//   in_rs1/in_rs2, in_rs*_used      source indices and use flags
//   in_rd/in_rd_valid/in_long       destination, write flag, long-latency flag
//   rf_rs1_data/rf_rs2_data         register-file read data
//   flush                           kill output register contents
//   out_valid/out_ready             execute handshake
//   out_op1/out_op2                 resolved operands (registered)
//   stall_cnt                       hazard-stall cycle count

module operand_bypass (
  input  logic        clk,
  input  logic        reset,
  input  logic [69:0] fwd_ex,
  input  logic [69:0] fwd_mem,
  input  logic [69:0] fwd_wb,
  input  logic        done_valid,
  input  logic [4:0]  done_dst,
  input  logic [63:0] done_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic        in_rs1_used,
  input  logic        in_rs2_used,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_valid,
  input  logic        in_long,
  input  logic [63:0] rf_rs1_data,
  input  logic [63:0] rf_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_op1,
  output logic [63:0] out_op2,
  output logic [31:0] stall_cnt
);

  logic [31:0] busy_q, busy_d;
  logic        out_valid_q;
  logic [63:0] out_op1_q, out_op2_q;
  logic        hazard, fire;
  logic        haz1, haz2, hazd;
  logic [63:0] op1_res, op2_res;

  // Youngest producer wins: EX, then MEM, then WB, then the completion port.
  function automatic logic [63:0] pick(input logic [4:0] idx, input logic [63:0] rf);
    if (idx == 5'd0) return 64'd0;
    if (fwd_ex[69] && fwd_ex[68:64] == idx) return fwd_ex[63:0];
    if (fwd_mem[69] && fwd_mem[68:64] == idx) return fwd_mem[63:0];
    if (fwd_wb[69] && fwd_wb[68:64] == idx) return fwd_wb[63:0];
    if (done_valid && done_dst == idx) return done_data;
    return rf;
  endfunction

  // A register completing this cycle is no longer a hazard; its data
  // arrives through the done port in the same cycle.
  function automatic logic blocked(input logic [4:0] idx);
    return (idx != 5'd0) && busy_q[idx] && !(done_valid && done_dst == idx);
  endfunction

  always_comb begin
    op1_res  = pick(in_rs1, rf_rs1_data);
    op2_res  = pick(in_rs2, rf_rs2_data);
    haz1     = in_rs1_used && blocked(in_rs1);
    haz2     = in_rs2_used && blocked(in_rs2);
    hazd     = in_rd_valid && blocked(in_rd);
    hazard   = haz1 || haz2 || hazd;
    in_ready = !hazard && (!out_valid_q || out_ready);
    fire     = in_valid && in_ready && !flush;
  end

  // Clear first, then set, so a same-cycle reissue to the completing
  // register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (done_valid) busy_d[done_dst] = 1'b0;
    if (fire && in_long && in_rd_valid && in_rd != 5'd0) busy_d[in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (fire) begin
        out_valid_q <= 1'b1;
        out_op1_q   <= op1_res;
        out_op2_q   <= op2_res;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (in_valid && hazard && !flush && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_operand_bypass.sv
// tb/tb_operand_bypass.sv - scoreboard bench for operand_bypass

module tb_operand_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic [69:0] fwd_ex, fwd_mem, fwd_wb;
  logic        done_valid;
  logic [4:0]  done_dst;
  logic [63:0] done_data;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_used, in_rs2_used, in_rd_valid, in_long;
  logic [63:0] rf_rs1_data, rf_rs2_data;
  logic        flush, out_valid, out_ready;
  logic [63:0] out_op1, out_op2;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] e;
  logic [31:0]  stall_exp;

  always #5 clk = ~clk;

  operand_bypass dut (
    .clk(clk), .reset(reset),
    .fwd_ex(fwd_ex), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .done_valid(done_valid), .done_dst(done_dst), .done_data(done_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_valid(in_rd_valid), .in_long(in_long),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs consumed by execute are compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("op1", out_op1, e[127:64]);
        chk("op2", out_op2, e[63:0]);
      end
    end
  end

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
    in_rd = 0; in_rd_valid = 0; in_long = 0; rf_rs1_data = 0; rf_rs2_data = 0;
    fwd_ex = 0; fwd_mem = 0; fwd_wb = 0;
    done_valid = 0; done_dst = 0; done_data = 0; flush = 0;
  endtask

  task automatic put(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic rdv, input logic lng,
                     input logic [63:0] rf1, input logic [63:0] rf2);
    in_valid = 1; in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = rd; in_rd_valid = rdv; in_long = lng; rf_rs1_data = rf1; rf_rs2_data = rf2;
  endtask

  task automatic done(input logic [4:0] d, input logic [63:0] v);
    done_valid = 1; done_dst = d; done_data = v;
  endtask

  // Advance to just after the next rising edge; inputs are then redriven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    out_ready = 1;
    reset = 1;
    step(); step();
    reset = 0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_op1", out_op1, 64'd0);
    chk("rst_op2", out_op2, 64'd0);
    chk("rst_stall", {32'd0, stall_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Forward priority: EX over MEM over RF.
    step(); put(5, 1, 0, 0, 0, 0, 0, 64'hC, 0);
    fwd_ex = {1'b1, 5'd5, 64'hA}; fwd_mem = {1'b1, 5'd5, 64'hB};
    #1; chk("prio_ready", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'hA, 64'h0});
    step(); fwd_ex[69] = 1'b0;
    #1; exp_q.push_back({64'hB, 64'h0});
    step(); fwd_mem[69] = 1'b0;
    #1; exp_q.push_back({64'hC, 64'h0});

    // x0 reads zero; WB forward on rs2.
    step(); idle(); put(0, 1, 3, 1, 0, 0, 0, 64'h77, 64'h88);
    fwd_ex = {1'b1, 5'd0, 64'hDEAD}; fwd_wb = {1'b1, 5'd3, 64'h33};
    #1; exp_q.push_back({64'h0, 64'h33});

    // Done port forwards to a non-busy register and has no other effect.
    step(); idle(); put(6, 1, 0, 0, 0, 0, 0, 64'h60, 0); done(6, 64'h66);
    #1; chk("done_fwd_ready", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h66, 64'h0});

    // Load-use on rd=7.
    step(); idle(); put(0, 0, 0, 0, 7, 1, 1, 0, 0);
    #1; exp_q.push_back({64'h0, 64'h0});
    step(); idle(); put(0, 0, 7, 1, 0, 0, 0, 0, 64'h99);
    for (int i = 0; i < 3; i++) begin
      #1; chk("lu_stall", {63'd0, in_ready}, 64'd0);
      step();
    end
`ifdef STALL_CNT_EN
    stall_exp = 32'd3;
`else
    stall_exp = 32'd0;
`endif
    chk("lu_stall_cnt", {32'd0, stall_cnt}, {32'd0, stall_exp});
    done(7, 64'h55);
    #1; chk("lu_done_ready", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h0, 64'h55});
    step(); idle(); put(7, 1, 0, 0, 0, 0, 0, 64'h71, 0);
    #1; chk("lu_stall_cnt_hold", {32'd0, stall_cnt}, {32'd0, stall_exp});
    chk("busy7_cleared", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h71, 64'h0});

    // WAW on rd=9.
    step(); idle(); put(0, 0, 0, 0, 9, 1, 1, 0, 0);
    #1; exp_q.push_back({64'h0, 64'h0});
    step(); idle(); put(0, 0, 0, 0, 9, 1, 0, 0, 0);
    #1; chk("waw_stall0", {63'd0, in_ready}, 64'd0);
    step();
    #1; chk("waw_stall1", {63'd0, in_ready}, 64'd0);
    step(); done(9, 64'hAB);
    #1; chk("waw_release", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h0, 64'h0});

    // Same-cycle done and reissue to rd=4 keeps it busy.
    step(); idle(); put(0, 0, 0, 0, 4, 1, 1, 0, 0);
    #1; exp_q.push_back({64'h0, 64'h0});
    step(); done(4, 64'h40);
    #1; chk("reissue_ready", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h0, 64'h0});
    step(); idle(); put(4, 1, 0, 0, 0, 0, 0, 64'h4F, 0);
    #1; chk("busy4_kept", {63'd0, in_ready}, 64'd0);
    step(); done(4, 64'h44);
    #1; chk("busy4_release", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h44, 64'h0});

    // Backpressure then flush; the long op's busy bit survives the flush.
    step(); idle();
    step(); out_ready = 0; put(1, 1, 0, 0, 12, 1, 1, 64'h11, 0);
    #1; chk("bp_first_ready", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h11, 64'h0});
    step(); idle(); put(2, 1, 0, 0, 0, 0, 0, 64'h22, 0);
    #1; chk("bp_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_op1", out_op1, 64'h11);
    step();
    #1; chk("bp_op1_hold", out_op1, 64'h11);
    chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
    idle(); flush = 1;
    step(); flush = 0;
    #1; chk("flush_valid", {63'd0, out_valid}, 64'd0);
    void'(exp_q.pop_front());
    out_ready = 1; put(12, 1, 0, 0, 0, 0, 0, 64'h12, 0);
    #1; chk("flush_busy_kept", {63'd0, in_ready}, 64'd0);
    step(); done(12, 64'hCC);
    #1; exp_q.push_back({64'hCC, 64'h0});

    // Flush suppresses fire: no output and no busy set.
    step(); idle(); put(0, 0, 0, 0, 13, 1, 1, 0, 0); flush = 1;
    step(); idle();
    #1; chk("flush_nofire", {63'd0, out_valid}, 64'd0);
    put(13, 1, 0, 0, 0, 0, 0, 64'hD13, 0);
    #1; chk("flush_nobusy", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'hD13, 64'h0});

    // Reset during a stall clears everything.
    step(); idle(); put(0, 0, 0, 0, 20, 1, 1, 0, 0);
    #1; exp_q.push_back({64'h0, 64'h0});
    step(); idle(); put(20, 1, 0, 0, 0, 0, 0, 64'h20, 0);
    #1; chk("pre_reset_stall", {63'd0, in_ready}, 64'd0);
    step(); reset = 1; in_valid = 0;
    step(); reset = 0;
    #1; chk("rst2_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_stall", {32'd0, stall_cnt}, 64'd0);
    chk("rst2_op1", out_op1, 64'd0);
    put(20, 1, 0, 0, 0, 0, 0, 64'h20, 0);
    #1; chk("rst2_busy_clear", {63'd0, in_ready}, 64'd1); exp_q.push_back({64'h20, 64'h0});
    step(); idle();
    step(); step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
